bounce_pixel_gen: RTL
=====================

# bounce_pixel_gen

Pixel generator for a single-player wall/paddle/ball game, sitting directly downstream of the VGA timing controller. It consumes the controller's pixel tick, video-on flag and x/y counts. It produces the 12-bit RGB value for the Basys 3 VGA DAC and advances game state (ball, paddle, counters) once per frame during vertical blank.

## Interface
- BALL_SIZE, 8: ball edge length in pixels (square)
- BALL_V, 2: ball step per frame on each axis
- PAD_X, 600: paddle left column; paddle occupies PAD_X..PAD_X+3
- PAD_H, 72: paddle height in pixels
- PAD_V, 4: paddle step per frame
- WALL_L, 32 / WALL_R, 35: left wall column span
- HD, 640 / VD, 480: display width / height
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-high
- p_tick  in  1  one-cycle pixel strobe, 1 in 4 clocks
- video_on  in  1  high inside the 640x480 display area
- x  in  10  current pixel column, 0-799
- y  in  10  current pixel row, 0-524
- btn_up, btn_down  in  1 each  synchronous, debounced paddle controls
- pause  in  1  freezes all game state while high
- rgb  out  12  registered pixel colour {R[3:0],G[3:0],B[3:0]}
- hits  out  8  paddle hit count, saturates at 255
- misses  out  4  missed-ball count, saturates at 15

## Operation
- refr_tick: combinational, high when p_tick && x==0 && y==VD. Asserts for exactly one clock per frame, in vertical blank.
- State registers: bx, by (ball top-left, 10b), dx, dy (1 = +, 0 = −), py (paddle top, 10b), hits, misses.
- Reset values: bx=316, by=236, dx=1, dy=1, py=204, hits=0, misses=0, rgb=0.
- On refr_tick with pause=0, all of the following are evaluated from pre-update values and committed together:
  - Vertical: if by <= BALL_V, then dy=1. Else if by+BALL_SIZE >= VD−BALL_V, then dy=0.
  - Left wall: if bx <= WALL_R+1+BALL_V, then dx=1.
  - Paddle hit: if dx==1, bx+BALL_SIZE >= PAD_X, bx < PAD_X+4, by+BALL_SIZE > py and by < py+PAD_H, then dx=0 and hits+=1 (saturating).
  - Miss: if bx+BALL_SIZE >= HD, then bx=316, by=236, dx=0, dy=1 and misses+=1 (saturating). Miss overrides all other ball updates.
  - Otherwise, bx and by step by ±BALL_V according to the new dx and dy.
  - Paddle up (btn_up && !btn_down): py = (py >= PAD_V) ? py−PAD_V : 0.
  - Paddle down (btn_down && !btn_up): py = (py+PAD_H+PAD_V <= VD) ? py+PAD_V : VD−PAD_H.
  - Both buttons or neither pressed: py holds.
- pause=1 at refr_tick: no state changes at all.
- Arithmetic: all sums are computed 11 bits wide so nothing overflows at the screen edges.
- Colour select on each p_tick, in priority order:
  - video_on=0: 12'h000
  - inside ball (x in bx..bx+BALL_SIZE−1, y in by..by+BALL_SIZE−1): 12'hF00
  - inside paddle (x in PAD_X..PAD_X+3, y in py..py+PAD_H−1): 12'h0F0
  - inside wall (x in WALL_L..WALL_R): 12'h00F
  - otherwise: background 12'h111

## Timing
- rgb is registered on clk_100MHz and enabled by p_tick. It reflects the x/y sampled at the p_tick edge and holds for 4 clocks until the next p_tick.
- Pipeline latency: one clock after the controller's x/y, which matches the controller's registered hsync/vsync.
- Game state changes only on the refr_tick edge, so it is constant across every visible line and no tearing occurs.
- Reset asserted mid-frame: all registers return to reset values immediately. rgb is 12'h000 until the first p_tick after release.
- hits and misses are registered and change only on refr_tick.

## Test plan
- Reset, then run one frame with pause=1:
  - pixel (316,236) -> rgb 12'hF00
  - (600,210) -> 12'h0F0
  - (33,100) -> 12'h00F
  - (100,100) -> 12'h111
  - (650,100) -> 12'h000
- From reset, 3 frames with no buttons -> bx=322, by=242; rgb register updates only on p_tick cycles.
- Force by=2, dy=0 at a refr_tick -> dy=1, by=4. Force by=470, dy=1 -> dy=0, by=468.
- Hold btn_up for 60 frames from py=204 -> py clamps at 0. Hold btn_down for 120 frames -> py=408. Both buttons held -> py unchanged.
- Place ball at bx=592, by=230, dx=1 with py=204 -> dx=0, hits=1.
- Place ball at bx=632 with the paddle away -> ball re-centred at (316,236), dx=0, misses=1. After 16 forced misses -> misses stays 15.
- Assert reset mid-frame -> rgb=0 and positions at reset values on the next clock.

Source files
------------

// File: rtl/bounce_pixel_gen.sv
// Pixel generator for the wall/paddle/ball game: colours each pixel from the
// current game state and advances the game once per frame in vertical blank.
module bounce_pixel_gen #(
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned BALL_V    = 2,
  parameter int unsigned PAD_X     = 600,
  parameter int unsigned PAD_H     = 72,
  parameter int unsigned PAD_V     = 4,
  parameter int unsigned WALL_L    = 32,
  parameter int unsigned WALL_R    = 35,
  parameter int unsigned HD        = 640,
  parameter int unsigned VD        = 480
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic [7:0]  hits,
  output logic [3:0]  misses
);

  // All geometry is evaluated 11 bits wide so edge sums cannot wrap.
  localparam int unsigned W = 11;
  localparam logic [W-1:0] SZ  = W'(BALL_SIZE);
  localparam logic [W-1:0] BV  = W'(BALL_V);
  localparam logic [W-1:0] PX  = W'(PAD_X);
  localparam logic [W-1:0] PW  = W'(4);
  localparam logic [W-1:0] PH  = W'(PAD_H);
  localparam logic [W-1:0] PV  = W'(PAD_V);
  localparam logic [W-1:0] WL  = W'(WALL_L);
  localparam logic [W-1:0] WR  = W'(WALL_R);
  localparam logic [W-1:0] HDW = W'(HD);
  localparam logic [W-1:0] VDW = W'(VD);

  localparam logic [9:0] BX_RST = 10'd316;
  localparam logic [9:0] BY_RST = 10'd236;
  localparam logic [9:0] PY_RST = 10'd204;

  localparam logic [11:0] C_OFF  = 12'h000;
  localparam logic [11:0] C_BALL = 12'hF00;
  localparam logic [11:0] C_PAD  = 12'h0F0;
  localparam logic [11:0] C_WALL = 12'h00F;
  localparam logic [11:0] C_BG   = 12'h111;

  logic [9:0] bx, by, py;
  logic       dx, dy;
  logic [9:0] bx_n, by_n, py_n;
  logic       dx_n, dy_n;
  logic [7:0] hits_n;
  logic [3:0] misses_n;

  logic [W-1:0] bx_w, by_w, py_w, x_w, y_w;
  logic         refr_tick_c, hit_c, miss_c;
  logic         in_ball_c, in_pad_c, in_wall_c;
  logic [11:0]  rgb_c;

  assign bx_w = {1'b0, bx};
  assign by_w = {1'b0, by};
  assign py_w = {1'b0, py};
  assign x_w  = {1'b0, x};
  assign y_w  = {1'b0, y};

  // One clock per frame, first pixel strobe of the first blanking line.
  assign refr_tick_c = p_tick && (x == 10'd0) && (y_w == VDW);

  assign hit_c  = dx && (bx_w + SZ >= PX) && (bx_w < PX + PW) &&
                  (by_w + SZ > py_w) && (by_w < py_w + PH);
  assign miss_c = (bx_w + SZ >= HDW);

  // Game update: every decision uses pre-update values, committed together.
  always_comb begin
    bx_n     = bx;
    by_n     = by;
    dx_n     = dx;
    dy_n     = dy;
    py_n     = py;
    hits_n   = hits;
    misses_n = misses;
    if (refr_tick_c && !pause) begin
      if (by_w <= BV) begin
        dy_n = 1'b1;
      end else if (by_w + SZ >= VDW - BV) begin
        dy_n = 1'b0;
      end
      if (bx_w <= WR + W'(1) + BV) begin
        dx_n = 1'b1;
      end
      if (hit_c) begin
        dx_n = 1'b0;
        if (hits != 8'hFF) hits_n = hits + 8'd1;
      end
      if (miss_c) begin
        bx_n = BX_RST;
        by_n = BY_RST;
        dx_n = 1'b0;
        dy_n = 1'b1;
        if (misses != 4'hF) misses_n = misses + 4'd1;
      end else begin
        bx_n = dx_n ? 10'(bx_w + BV) : 10'(bx_w - BV);
        by_n = dy_n ? 10'(by_w + BV) : 10'(by_w - BV);
      end
      if (btn_up && !btn_down) begin
        py_n = (py_w >= PV) ? 10'(py_w - PV) : 10'd0;
      end else if (btn_down && !btn_up) begin
        py_n = (py_w + PH + PV <= VDW) ? 10'(py_w + PV) : 10'(VDW - PH);
      end
    end
  end

  assign in_ball_c = (x_w >= bx_w) && (x_w < bx_w + SZ) &&
                     (y_w >= by_w) && (y_w < by_w + SZ);
  assign in_pad_c  = (x_w >= PX) && (x_w < PX + PW) &&
                     (y_w >= py_w) && (y_w < py_w + PH);
  assign in_wall_c = (x_w >= WL) && (x_w <= WR);

  // Priority colour select for the current pixel.
  always_comb begin
    rgb_c = C_BG;
    if (!video_on)      rgb_c = C_OFF;
    else if (in_ball_c) rgb_c = C_BALL;
    else if (in_pad_c)  rgb_c = C_PAD;
    else if (in_wall_c) rgb_c = C_WALL;
  end

  // Game state and pixel registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      bx     <= BX_RST;
      by     <= BY_RST;
      dx     <= 1'b1;
      dy     <= 1'b1;
      py     <= PY_RST;
      hits   <= 8'd0;
      misses <= 4'd0;
      rgb    <= C_OFF;
    end else begin
      bx     <= bx_n;
      by     <= by_n;
      dx     <= dx_n;
      dy     <= dy_n;
      py     <= py_n;
      hits   <= hits_n;
      misses <= misses_n;
      if (p_tick) rgb <= rgb_c;
    end
  end

endmodule
